ascon_out_serializer: RTL and testbench

- Streams ASCON output blocks from the permutation datapath onto a narrow word bus using a valid/ready handshake.
- Once the state register holds a finished ciphertext block or a finalisation tag, the controller pulses a load. This block captures the value in one cycle and emits it most-significant word first.
- It sits between the state datapath and the external output port, on the read side of the ASCON state storage.

---
 rtl/ascon_out_serializer.sv | 87 ++++++++
 tb/tb_ascon_out_serializer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ascon_out_serializer.sv
// ascon_out_serializer: streams a captured ASCON cipher block or tag onto a word bus, MSB word first
//   clock_i       rising-edge clock
//   resetb_i      asynchronous active-low reset
//   load_i        capture request, honoured only while load_ready_o=1
//   mode_i        0 = 64-bit cipher block from data_i[63:0], 1 = 128-bit tag from data_i[127:0]
//   data_i        block/tag value to capture
//   load_ready_o  idle and able to accept a load
//   out_data_o    current output word
//   out_valid_o   out_data_o is valid
//   out_ready_i   sink accepts the current word
//   out_last_o    current word is the last of the transfer
//   out_tag_o     current transfer is a tag
//   done_o        one-cycle pulse after the final word is accepted
module ascon_out_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              load_i,
    input  logic              mode_i,
    input  logic [127:0]      data_i,
    output logic              load_ready_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              out_tag_o,
    output logic              done_o
);
    localparam logic [2:0] BLK_N = 3'(64 / WORD_W);
    localparam logic [2:0] TAG_N = 3'(128 / WORD_W);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state_q, state_d;
    logic [127:0] shreg_q, shreg_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         tag_q, tag_d;
    logic         done_q, done_d;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            tag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (load_i) begin
                // a cipher block is left-aligned so the same MSB-first shift serves both modes
                shreg_d = mode_i ? data_i : {data_i[63:0], 64'h0};
                cnt_d   = mode_i ? TAG_N : BLK_N;
                tag_d   = mode_i;
                state_d = SEND;
            end
        end else if (out_ready_i) begin
            shreg_d = shreg_q << WORD_W;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign load_ready_o = (state_q == IDLE);
    assign out_valid_o  = (state_q == SEND);
    assign out_data_o   = shreg_q[127 -: WORD_W];
    assign out_last_o   = (state_q == SEND) && (cnt_q == 3'd1);
    assign out_tag_o    = tag_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_ascon_out_serializer.sv
// tb_ascon_out_serializer: directed table-driven check of ascon_out_serializer at WORD_W=32
module tb_ascon_out_serializer;
    localparam logic [127:0] T1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] T2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] C1 = {64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_01234567};
    localparam logic [127:0] C2 = {64'hFFFFFFFF_FFFFFFFF, 64'hCAFEBABE_12345678};

    logic         clk = 1'b0;
    logic         resetb = 1'b1;
    logic         load = 1'b0;
    logic         mode = 1'b0;
    logic [127:0] din = '0;
    logic         rdy = 1'b0;
    logic         lr, valid, last, tag, done;
    logic [31:0]  dout;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic         ld;
        logic         md;
        logic [127:0] d;
        logic         rd;
        logic [36:0]  exp;
    } vec_t;

    vec_t tv[$];

    ascon_out_serializer #(.WORD_W(32)) dut (
        .clock_i(clk),
        .resetb_i(resetb),
        .load_i(load),
        .mode_i(mode),
        .data_i(din),
        .load_ready_o(lr),
        .out_data_o(dout),
        .out_valid_o(valid),
        .out_ready_i(rdy),
        .out_last_o(last),
        .out_tag_o(tag),
        .done_o(done)
    );

    always #5 clk = ~clk;

    // expected output record: {load_ready, valid, last, tag, done, data}
    function automatic logic [36:0] idl(input logic d, input logic t);
        return {1'b1, 1'b0, 1'b0, t, d, 32'h0};
    endfunction

    function automatic logic [36:0] snd(input logic [31:0] w, input logic l, input logic t);
        return {1'b0, 1'b1, l, t, 1'b0, w};
    endfunction

    function automatic vec_t mk(input logic ld, input logic md, input logic [127:0] d,
                                input logic rd, input logic [36:0] exp);
        vec_t v;
        v.ld = ld; v.md = md; v.d = d; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [36:0] exp);
        logic [36:0] got;
        got = {lr, valid, last, tag, done, dout};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got lr/v/last/tag/done=%b%b%b%b%b data=%h, expected %b%b%b%b%b data=%h",
                     nm, got[36], got[35], got[34], got[33], got[32], got[31:0],
                     exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic step(input logic ld, input logic md, input logic [127:0] d, input logic rd,
                        input string nm, input logic [36:0] exp);
        load = ld; mode = md; din = d; rdy = rd;
        @(posedge clk);
        #1;
        chk(nm, exp);
    endtask

    initial begin
        // idle
        tv.push_back(mk(0, 0, '0, 0, idl(0, 0)));
        // tag, ready held high
        tv.push_back(mk(1, 1, T1, 1, snd(32'h00112233, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h44556677, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h8899AABB, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'hCCDDEEFF, 1, 1)));
        tv.push_back(mk(0, 0, '0, 1, idl(1, 1)));
        // cipher block loaded in the first idle cycle, upper bits ignored
        tv.push_back(mk(1, 0, C1, 0, snd(32'hDEADBEEF, 0, 0)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h01234567, 1, 0)));
        tv.push_back(mk(0, 0, '0, 1, idl(1, 0)));
        // backpressure 1,0,0,1,0,1,1
        tv.push_back(mk(1, 1, T2, 0, snd(32'h01234567, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h89ABCDEF, 0, 1)));
        tv.push_back(mk(0, 0, '0, 0, snd(32'h89ABCDEF, 0, 1)));
        tv.push_back(mk(0, 0, '0, 0, snd(32'h89ABCDEF, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'hFEDCBA98, 0, 1)));
        tv.push_back(mk(0, 0, '0, 0, snd(32'hFEDCBA98, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h76543210, 1, 1)));
        tv.push_back(mk(0, 0, '0, 1, idl(1, 1)));
        tv.push_back(mk(0, 0, '0, 0, idl(0, 1)));
        // load collisions during SEND and with the final handshake
        tv.push_back(mk(1, 1, T1, 0, snd(32'h00112233, 0, 1)));
        tv.push_back(mk(1, 0, C2, 0, snd(32'h00112233, 0, 1)));
        tv.push_back(mk(1, 0, C2, 1, snd(32'h44556677, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h8899AABB, 0, 1)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'hCCDDEEFF, 1, 1)));
        tv.push_back(mk(1, 0, C2, 1, idl(1, 1)));
        tv.push_back(mk(1, 0, C2, 0, snd(32'hCAFEBABE, 0, 0)));
        tv.push_back(mk(0, 0, '0, 1, snd(32'h12345678, 1, 0)));
        tv.push_back(mk(0, 0, '0, 1, idl(1, 0)));
        // out_ready in idle does nothing
        tv.push_back(mk(0, 0, '0, 1, idl(0, 0)));
        tv.push_back(mk(0, 1, T2, 1, idl(0, 0)));

        // asynchronous reset asserted mid-cycle, before any clock edge
        #2 resetb = 1'b0;
        #1 chk("reset_async", idl(0, 0));
        @(posedge clk);
        #1 chk("reset_held", idl(0, 0));
        #2 resetb = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i])
            step(tv[i].ld, tv[i].md, tv[i].d, tv[i].rd, $sformatf("vec%0d", i), tv[i].exp);

        // reset after two of four tag words
        step(1, 1, T1, 1, "rst_w0", snd(32'h00112233, 0, 1));
        step(0, 0, '0, 1, "rst_w1", snd(32'h44556677, 0, 1));
        step(0, 0, '0, 1, "rst_w2", snd(32'h8899AABB, 0, 1));
        #2 resetb = 1'b0;
        #1 chk("rst_mid", idl(0, 0));
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1, "rst_hold", idl(0, 0));
        resetb = 1'b1;
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1, "rst_nodone", idl(0, 0));
        step(1, 1, T2, 1, "post_w0", snd(32'h01234567, 0, 1));
        step(0, 0, '0, 1, "post_w1", snd(32'h89ABCDEF, 0, 1));
        step(0, 0, '0, 1, "post_w2", snd(32'hFEDCBA98, 0, 1));
        step(0, 0, '0, 1, "post_w3", snd(32'h76543210, 1, 1));
        step(0, 0, '0, 1, "post_done", idl(1, 1));
        step(0, 0, '0, 0, "post_idle", idl(0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
